// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   idx_w(n)  - width of an index into n requesters, never less than 1
//   count_t   - occupancy/credit counter type for the default FIFO size
//   lock_t    - packet-lock state (owner valid + owner index); the id field
//               is wide enough for the largest supported NREQ (16)
package fifo_arb_pkg;

  localparam int ARB_ASIZE    = 2;
  localparam int ARB_ID_W_MAX = 4;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [ARB_ASIZE:0] count_t;

  typedef struct packed {
    logic                    vld;
    logic [ARB_ID_W_MAX-1:0] id;
  } lock_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle, FIFO write port and status of the
// arbiter.
//   master - environment side: drives requests and fifo_pop, sees grants
//   slave  - arbiter side: receives requests, drives ready/winc/wdata/
//            grant_id/occupancy
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int ASIZE = ARB_ASIZE
) ();

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_pop;
  logic [IW-1:0]         grant_id;
  logic [ASIZE:0]        occupancy;

  modport master (
    output req_valid, req_data, req_last, fifo_pop,
    input  req_ready, fifo_wdata, fifo_winc, grant_id, occupancy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_pop,
    output req_ready, fifo_wdata, fifo_winc, grant_id, occupancy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   i_req    - request vector (already masked by any lock)
//   i_rr_ptr - index holding highest priority this cycle (< NREQ)
//   o_found  - at least one request present
//   o_pick   - first requesting index scanning i_rr_ptr, i_rr_ptr+1, ... mod NREQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [idx_w(NREQ)-1:0]  i_rr_ptr,
  output logic                    o_found,
  output logic [idx_w(NREQ)-1:0]  o_pick
);

  localparam int IW = idx_w(NREQ);

  int w_idx;

  // Scan from lowest priority to highest so the last hit (highest priority) wins.
  always_comb begin
    o_found = 1'b0;
    o_pick  = '0;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(i_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (i_req[IW'(w_idx)]) begin
        o_found = 1'b1;
        o_pick  = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ
// requesters. FIFO occupancy is tracked by a local credit counter, so issue
// never depends on the FIFO's full flag.
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   bus        - fifo_wr_arbiter_if.slave: req_valid/req_data/req_last in,
//                req_ready/fifo_winc/fifo_wdata/grant_id out, fifo_pop in,
//                occupancy (credit count 0..DEPTH) out
// Optional feature: define FIFO_ARB_PKT_LOCK_EN to hold a grant on the owning
// requester until it presents a beat with req_last=1.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int ASIZE = ARB_ASIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int             IW       = idx_w(NREQ);
  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0]   r_rr_ptr;
  logic [ASIZE:0]  r_count;

  logic [NREQ-1:0] w_req;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_pick_inc;
  logic            w_space;
  logic            w_acc;
  logic            w_adv;
  logic            w_pop_eff;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_pick   (w_pick)
  );

  assign w_space    = (r_count != DEPTH_C);
  // rst_n gating keeps every output at 0 while reset is held.
  assign w_acc      = rst_n && w_space && w_found;
  assign w_pick_inc = (w_pick == LAST_IDX) ? '0 : w_pick + IW'(1);
  assign w_pop_eff  = bus.fifo_pop && (r_count != '0);

`ifdef FIFO_ARB_PKT_LOCK_EN
  lock_t r_lock;

  always_comb begin
    w_req = bus.req_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (r_lock.vld && (r_lock.id != ARB_ID_W_MAX'(i))) w_req[i] = 1'b0;
    end
  end

  // Priority only rotates once the packet ends.
  assign w_adv = w_acc && bus.req_last[w_pick];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= '0;
    end else if (w_acc) begin
      r_lock.vld <= ~bus.req_last[w_pick];
      r_lock.id  <= ARB_ID_W_MAX'(w_pick);
    end
  end
`else
  assign w_req = bus.req_valid;
  assign w_adv = w_acc;
`endif

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_winc  = 1'b0;
    bus.fifo_wdata = '0;
    bus.grant_id   = '0;
    if (w_acc) begin
      bus.req_ready[w_pick] = 1'b1;
      bus.fifo_winc         = 1'b1;
      bus.fifo_wdata        = bus.req_data[int'(w_pick) * DSIZE +: DSIZE];
      bus.grant_id          = w_pick;
    end
  end

  assign bus.occupancy = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_adv) begin
      r_rr_ptr <= w_pick_inc;
    end
  end

  // Write and pop together cancel; a pop against an empty count is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_acc && !w_pop_eff) begin
      r_count <= r_count + (ASIZE + 1)'(1);
    end else if (!w_acc && w_pop_eff) begin
      r_count <= r_count - (ASIZE + 1)'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int ASIZE = 2;

  typedef struct {
    int               id;
    logic [DSIZE-1:0] data;
  } exp_t;

  logic   clk;
  logic   rst_n;
  exp_t   exp_q[$];
  count_t m_cnt;
  int     n_assert;
  int     n_fail;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE)) bus_if ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DSIZE-1:0] data_of(input int i);
    return DSIZE'((i + 1) * 8'h11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on negedge, check combinational outputs #1 later,
  // check occupancy #1 after the following posedge.
  task automatic cycle(input string tag, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                       input logic p, input logic exp_acc, input int exp_id);
    exp_t e;
    @(negedge clk);
    bus_if.req_valid = v;
    bus_if.req_last  = l;
    bus_if.fifo_pop  = p;
    if (exp_acc) exp_q.push_back('{id: exp_id, data: data_of(exp_id)});
    #1;
    chk({tag, ".winc"}, 32'(bus_if.fifo_winc), 32'(exp_acc));
    if (bus_if.fifo_winc === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_winc"}, 32'(bus_if.grant_id), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".grant_id"}, 32'(bus_if.grant_id), 32'(e.id));
        chk({tag, ".wdata"}, 32'(bus_if.fifo_wdata), 32'(e.data));
        chk({tag, ".ready"}, 32'(bus_if.req_ready), 32'(1) << e.id);
      end
    end else begin
      exp_q.delete();
      chk({tag, ".ready0"}, 32'(bus_if.req_ready), 32'h0);
      chk({tag, ".wdata0"}, 32'(bus_if.fifo_wdata), 32'h0);
      chk({tag, ".grant0"}, 32'(bus_if.grant_id), 32'h0);
    end
    if (exp_acc && !(p && m_cnt != 0)) m_cnt = m_cnt + 1'b1;
    else if (!exp_acc && p && m_cnt != 0) m_cnt = m_cnt - 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".occupancy"}, 32'(bus_if.occupancy), 32'(m_cnt));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_cnt    = '0;
    rst_n    = 1'b0;
    bus_if.req_valid = '1;
    bus_if.req_last  = '1;
    bus_if.fifo_pop  = 1'b0;
    for (int i = 0; i < NREQ; i++) bus_if.req_data[i*DSIZE +: DSIZE] = data_of(i);

    // Reset: outputs held at zero even with all requests valid
    #2;
    chk("rst.ready", 32'(bus_if.req_ready), 32'h0);
    chk("rst.winc", 32'(bus_if.fifo_winc), 32'h0);
    chk("rst.wdata", 32'(bus_if.fifo_wdata), 32'h0);
    chk("rst.grant", 32'(bus_if.grant_id), 32'h0);
    chk("rst.occupancy", 32'(bus_if.occupancy), 32'h0);
    @(posedge clk); #1;
    chk("rst.occupancy_edge", 32'(bus_if.occupancy), 32'h0);
    @(negedge clk);
    bus_if.req_valid = '0;
    rst_n = 1'b1;

    // Basic round-robin with a pop every cycle
    cycle("rr0", 4'hF, 4'hF, 1'b1, 1'b1, 0);
    cycle("rr1", 4'hF, 4'hF, 1'b1, 1'b1, 1);
    cycle("rr2", 4'hF, 4'hF, 1'b1, 1'b1, 2);
    cycle("rr3", 4'hF, 4'hF, 1'b1, 1'b1, 3);
    cycle("rr4", 4'hF, 4'hF, 1'b1, 1'b1, 0);
    cycle("rr5", 4'hF, 4'hF, 1'b1, 1'b1, 1);
    cycle("drain", 4'h0, 4'hF, 1'b1, 1'b0, 0);

    // Full stall: four accepts, then a pop frees exactly one slot next cycle
    cycle("full0", 4'hF, 4'hF, 1'b0, 1'b1, 2);
    cycle("full1", 4'hF, 4'hF, 1'b0, 1'b1, 3);
    cycle("full2", 4'hF, 4'hF, 1'b0, 1'b1, 0);
    cycle("full3", 4'hF, 4'hF, 1'b0, 1'b1, 1);
    cycle("stall", 4'hF, 4'hF, 1'b0, 1'b0, 0);
    cycle("stall_pop", 4'hF, 4'hF, 1'b1, 1'b0, 0);
    cycle("after_pop", 4'hF, 4'hF, 1'b0, 1'b1, 2);
    cycle("stall2", 4'hF, 4'hF, 1'b0, 1'b0, 0);

    // Write+pop at count 2, then pop at empty
    cycle("pop4", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("pop3", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("wr_pop2", 4'hF, 4'hF, 1'b1, 1'b1, 3);
    cycle("pop2", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("pop1", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("pop_empty", 4'h0, 4'hF, 1'b1, 1'b0, 0);

    // Sparse requests: rr_ptr becomes 2, only req 0 valid, then rr_ptr=1
    cycle("sp_set", 4'b0010, 4'hF, 1'b0, 1'b1, 1);
    cycle("sp_wrap", 4'b0001, 4'hF, 1'b0, 1'b1, 0);
    cycle("sp_ptr1", 4'b0011, 4'hF, 1'b0, 1'b1, 1);
    cycle("sp_d0", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("sp_d1", 4'h0, 4'hF, 1'b1, 1'b0, 0);
    cycle("sp_d2", 4'h0, 4'hF, 1'b1, 1'b0, 0);

    // Packet from req 1 (last on third beat) with req 0 and 2 also valid
    cycle("pk_pre", 4'b0001, 4'hF, 1'b1, 1'b1, 0);
`ifdef FIFO_ARB_PKT_LOCK_EN
    cycle("pk_b0", 4'b0111, 4'b0101, 1'b1, 1'b1, 1);
    cycle("pk_b1", 4'b0111, 4'b0101, 1'b1, 1'b1, 1);
    cycle("pk_b2", 4'b0111, 4'b0111, 1'b1, 1'b1, 1);
    cycle("pk_b3", 4'b0111, 4'b0111, 1'b1, 1'b1, 2);
`else
    cycle("pk_b0", 4'b0111, 4'b0101, 1'b1, 1'b1, 1);
    cycle("pk_b1", 4'b0111, 4'b0101, 1'b1, 1'b1, 2);
    cycle("pk_b2", 4'b0111, 4'b0111, 1'b1, 1'b1, 0);
    cycle("pk_b3", 4'b0111, 4'b0111, 1'b1, 1'b1, 1);
`endif

    // Reset in the middle of a packet
    cycle("mid_pkt", 4'b0010, 4'b0000, 1'b1, 1'b1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.req_valid = '1;
    bus_if.req_last  = '0;
    bus_if.fifo_pop  = 1'b0;
    #1;
    m_cnt = '0;
    exp_q.delete();
    chk("mrst.ready", 32'(bus_if.req_ready), 32'h0);
    chk("mrst.winc", 32'(bus_if.fifo_winc), 32'h0);
    chk("mrst.wdata", 32'(bus_if.fifo_wdata), 32'h0);
    chk("mrst.grant", 32'(bus_if.grant_id), 32'h0);
    chk("mrst.occupancy", 32'(bus_if.occupancy), 32'h0);
    @(negedge clk);
    bus_if.req_valid = '0;
    rst_n = 1'b1;
    cycle("post_rst0", 4'hF, 4'hF, 1'b0, 1'b1, 0);
    cycle("post_rst1", 4'hF, 4'hF, 1'b0, 1'b1, 1);
    cycle("post_rst2", 4'hF, 4'hF, 1'b0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
